ps2_kbd_decoder: RTL and testbench
==================================

PS2_KBD_DECODER -- requirements
Module: ps2_kbd_decoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, key FIFO depth in entries; SHALL be a power of two, 2..64.
REQ-002 clk  input  1  system clock; all state SHALL be on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 rx_done_tick  input  1  one-cycle strobe; rx_data is valid in this cycle.
REQ-005 rx_data  input  8  received PS/2 set-2 byte.
REQ-006 rd_en  input  1  CPU pop strobe for the key FIFO.
REQ-007 key_data  output  8  FIFO head, first-word-fall-through; SHALL be 0x00 when empty.
REQ-008 key_empty  output  1  FIFO holds zero entries.
REQ-009 key_full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-010 overflow  output  1  sticky flag: a key was dropped because the FIFO was full.

Function
REQ-011 Prefix FSM states SHALL be IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0); it SHALL advance only in cycles where rx_done_tick=1.
REQ-012 Transitions: IDLE+E0->EXT; IDLE+F0->BRK; EXT+F0->EXT_BRK; any other byte in any state->IDLE after processing; EXT+E0 SHALL stay in EXT.
REQ-013 Byte received in IDLE (not E0/F0) = make code; in BRK = break code; in EXT or EXT_BRK = extended code, discarded in both cases.
REQ-014 Make code 0x12 or 0x59 SHALL set shift_l or shift_r respectively and SHALL NOT push.
REQ-015 Break code 0x12 or 0x59 SHALL clear shift_l or shift_r respectively; no other break code SHALL have any effect.
REQ-016 Any other make code SHALL push one entry (per Configuration) on the clock edge where rx_done_tick=1; key_empty SHALL deassert in the following cycle (latency 1).
REQ-017 Typematic repeats, i.e. repeated make codes with no break between them, SHALL each push.
REQ-018 Pop: rd_en=1 with key_empty=0 SHALL remove the head on that edge; rd_en with key_empty=1 SHALL be ignored.
REQ-019 Push while full with no pop in the same cycle SHALL drop the key and set overflow; FIFO contents SHALL be unchanged.
REQ-020 Push and pop in the same cycle SHALL both take effect, including when full; occupancy is unchanged and overflow is not set.
REQ-021 Read/write pointers SHALL be log2(FIFO_DEPTH) bits, wrap modulo FIFO_DEPTH, plus an occupancy count of log2(FIFO_DEPTH)+1 bits.
REQ-022 overflow SHALL remain set until reset.

Reset
REQ-023 Reset SHALL force: FSM to IDLE, shift_l=shift_r=0, pointers and count=0, key_empty=1, key_full=0, overflow=0, key_data=0x00.
REQ-024 Reset asserted mid-sequence (e.g. after E0 or F0) SHALL discard the pending prefix; the next byte SHALL be decoded from IDLE.

Configuration
REQ-025 With macro PS2_ASCII_EN defined: each make code SHALL be translated to ASCII before push.
- Letters: lowercase; uppercase when shift_l|shift_r.
- Digits 0-9: shifted symbols !@#$%^&*() when shifted.
- 0x29->0x20, 0x5A->0x0D, 0x66->0x08.
- Unmapped codes SHALL be discarded without pushing.
REQ-026 Without PS2_ASCII_EN: the raw make code SHALL be pushed unchanged; shift state is still tracked but unused; the translation ROM SHALL be absent.

Structure
REQ-027 Shared package ps2_pkg SHALL hold the FSM state typedef and the constants SC_EXT=0xE0, SC_BRK=0xF0, SC_LSHIFT=0x12, SC_RSHIFT=0x59.
REQ-028 The FIFO SHALL be a separate sub-module, ps2_key_fifo, parameterised by depth and width; the translation SHALL be a combinational function in ps2_pkg.

Verification
REQ-029 With PS2_ASCII_EN, bytes 1C, F0, 1C -> exactly one entry 0x61; key_empty falls 1 cycle after the first tick.
REQ-030 With PS2_ASCII_EN, bytes 12, 1C, F0, 1C, F0, 12, 1C -> entries 0x41 then 0x61.
REQ-031 Bytes E0, 75, E0, F0, 75 -> no push; FSM in IDLE afterwards; next byte 0x16 -> 0x31 (ASCII) or 0x16 (raw).
REQ-032 FIFO_DEPTH=8: nine make codes with no reads -> key_full=1, overflow=1, the 8 oldest keys are read back in order, and the ninth is absent.
REQ-033 FIFO full with rd_en coincident with a push tick -> count stays 8, overflow stays 0, head advances.
REQ-034 Reset pulse after byte F0 -> outputs at reset values; then 0x1C -> one push (0x61 or 0x1C).

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 set-2 decoder definitions: prefix FSM states, scan-code constants and the
// scan-code to ASCII translation used when PS2_ASCII_EN is defined.
package ps2_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;

    typedef logic [1:0] ps2_state_t;

    localparam ps2_state_t ST_IDLE    = 2'd0;
    localparam ps2_state_t ST_EXT     = 2'd1;
    localparam ps2_state_t ST_BRK     = 2'd2;
    localparam ps2_state_t ST_EXT_BRK = 2'd3;

    typedef struct packed {
        logic       valid;
        logic [7:0] code;
    } ps2_key_t;

    function automatic ps2_key_t scan_to_ascii(input logic [7:0] sc, input logic shift);
        ps2_key_t k;
        logic     is_letter;
        k.valid   = 1'b1;
        k.code    = 8'h00;
        is_letter = 1'b1;
        case (sc)
            8'h1C: k.code = 8'h61;  // a
            8'h32: k.code = 8'h62;
            8'h21: k.code = 8'h63;
            8'h23: k.code = 8'h64;
            8'h24: k.code = 8'h65;
            8'h2B: k.code = 8'h66;
            8'h34: k.code = 8'h67;
            8'h33: k.code = 8'h68;
            8'h43: k.code = 8'h69;
            8'h3B: k.code = 8'h6A;
            8'h42: k.code = 8'h6B;
            8'h4B: k.code = 8'h6C;
            8'h3A: k.code = 8'h6D;
            8'h31: k.code = 8'h6E;
            8'h44: k.code = 8'h6F;
            8'h4D: k.code = 8'h70;
            8'h15: k.code = 8'h71;
            8'h2D: k.code = 8'h72;
            8'h1B: k.code = 8'h73;
            8'h2C: k.code = 8'h74;
            8'h3C: k.code = 8'h75;
            8'h2A: k.code = 8'h76;
            8'h1D: k.code = 8'h77;
            8'h22: k.code = 8'h78;
            8'h35: k.code = 8'h79;
            8'h1A: k.code = 8'h7A;  // z
            default: begin
                is_letter = 1'b0;
                case (sc)
                    8'h16: k.code = shift ? 8'h21 : 8'h31;
                    8'h1E: k.code = shift ? 8'h40 : 8'h32;
                    8'h26: k.code = shift ? 8'h23 : 8'h33;
                    8'h25: k.code = shift ? 8'h24 : 8'h34;
                    8'h2E: k.code = shift ? 8'h25 : 8'h35;
                    8'h36: k.code = shift ? 8'h5E : 8'h36;
                    8'h3D: k.code = shift ? 8'h26 : 8'h37;
                    8'h3E: k.code = shift ? 8'h2A : 8'h38;
                    8'h46: k.code = shift ? 8'h28 : 8'h39;
                    8'h45: k.code = shift ? 8'h29 : 8'h30;
                    8'h29: k.code = 8'h20;
                    8'h5A: k.code = 8'h0D;
                    8'h66: k.code = 8'h08;
                    default: k.valid = 1'b0;
                endcase
            end
        endcase
        if (is_letter && shift) begin
            k.code = k.code - 8'h20;
        end
        return k;
    endfunction

endpackage

// File: rtl/ps2_key_fifo.sv
// Key FIFO: first-word-fall-through head (0x00 when empty), occupancy count and a sticky
// overflow flag set when a push is dropped because the FIFO is full.
module ps2_key_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full,
    output logic             overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             overflow_q;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_CNT);
    assign overflow = overflow_q;
    assign head     = empty ? '0 : mem[rd_ptr_q];

    // A pop frees the slot in the same edge, so a push while full still lands.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (push && !do_push) begin
                overflow_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_kbd_decoder.sv
// PS/2 set-2 keyboard decoder: prefix FSM, shift tracking and key FIFO.
// Define PS2_ASCII_EN to translate make codes to ASCII before pushing.
module ps2_kbd_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    input  logic       rd_en,
    output logic [7:0] key_data,
    output logic       key_empty,
    output logic       key_full,
    output logic       overflow
);

    ps2_state_t state_q, state_d;
    logic       shift_l_q, shift_l_d;
    logic       shift_r_q, shift_r_d;
    logic       make_valid;
    logic       push;
    logic [7:0] push_data;

    always_comb begin
        state_d    = state_q;
        shift_l_d  = shift_l_q;
        shift_r_d  = shift_r_q;
        make_valid = 1'b0;
        if (rx_done_tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_data == SC_EXT) begin
                        state_d = ST_EXT;
                    end else if (rx_data == SC_BRK) begin
                        state_d = ST_BRK;
                    end else begin
                        state_d = ST_IDLE;
                        if (rx_data == SC_LSHIFT) begin
                            shift_l_d = 1'b1;
                        end else if (rx_data == SC_RSHIFT) begin
                            shift_r_d = 1'b1;
                        end else begin
                            make_valid = 1'b1;
                        end
                    end
                end
                ST_EXT: begin
                    if (rx_data == SC_EXT) begin
                        state_d = ST_EXT;
                    end else if (rx_data == SC_BRK) begin
                        state_d = ST_EXT_BRK;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    state_d = ST_IDLE;
                    if (rx_data == SC_LSHIFT) begin
                        shift_l_d = 1'b0;
                    end else if (rx_data == SC_RSHIFT) begin
                        shift_r_d = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            shift_l_q <= 1'b0;
            shift_r_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_l_q <= shift_l_d;
            shift_r_q <= shift_r_d;
        end
    end

`ifdef PS2_ASCII_EN
    ps2_key_t xlat;

    assign xlat      = scan_to_ascii(rx_data, shift_l_q | shift_r_q);
    assign push      = make_valid && xlat.valid;
    assign push_data = xlat.code;
`else
    // Shift state is kept so the ASCII build behaves identically; nothing reads it here.
    logic unused_shift;

    assign unused_shift = shift_l_q ^ shift_r_q;
    assign push         = make_valid;
    assign push_data    = rx_data;
`endif

    ps2_key_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (rd_en),
        .head      (key_data),
        .empty     (key_empty),
        .full      (key_full),
        .overflow  (overflow)
    );

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// Directed bench for ps2_kbd_decoder; expected keys follow the build (PS2_ASCII_EN or raw).
module tb_ps2_kbd_decoder;

`ifdef PS2_ASCII_EN
    localparam bit ASCII = 1'b1;
`else
    localparam bit ASCII = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rd_en = 1'b0;
    logic [7:0] key_data;
    logic       key_empty;
    logic       key_full;
    logic       overflow;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] sc_tab [9] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
    logic [7:0] as_tab [9] = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h69};

    ps2_kbd_decoder #(
        .FIFO_DEPTH (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .rd_en        (rd_en),
        .key_data     (key_data),
        .key_empty    (key_empty),
        .key_full     (key_full),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ek(input logic [7:0] raw, input logic [7:0] asc);
        return ASCII ? asc : raw;
    endfunction

    // Inputs change on the falling edge; outputs are sampled there too.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data      = b;
        rx_done_tick = 1'b1;
        @(negedge clk);
        rx_done_tick = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check(tag, {24'h0, key_data}, {24'h0, exp});
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_empty"}, {31'h0, key_empty}, 32'h1);
        check({tag, "_full"}, {31'h0, key_full}, 32'h0);
        check({tag, "_ovf"}, {31'h0, overflow}, 32'h0);
        check({tag, "_data"}, {24'h0, key_data}, 32'h0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_reset_state("rst");

        // Make, break of same key: one entry, visible one cycle after the tick.
        @(negedge clk);
        rx_data      = 8'h1C;
        rx_done_tick = 1'b1;
        check("lat_before", {31'h0, key_empty}, 32'h1);
        @(negedge clk);
        rx_done_tick = 1'b0;
        check("lat_after", {31'h0, key_empty}, 32'h0);
        send(8'hF0);
        send(8'h1C);
        pop_check("a_make", ek(8'h1C, 8'h61));
        check("a_one_entry", {31'h0, key_empty}, 32'h1);

        // Left shift held around a letter, then released.
        send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C);
        send(8'hF0); send(8'h12); send(8'h1C);
        pop_check("shift_A", ek(8'h1C, 8'h41));
        pop_check("unshift_a", ek(8'h1C, 8'h61));
        check("shift_done", {31'h0, key_empty}, 32'h1);

        // Extended make/break discarded; next byte decoded from idle.
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        check("ext_nopush", {31'h0, key_empty}, 32'h1);
        send(8'h16);
        pop_check("after_ext", ek(8'h16, 8'h31));

        // Repeated E0 stays extended; extended break of shift leaves shift held.
        send(8'hE0); send(8'hE0); send(8'h16);
        check("ext_e0_e0", {31'h0, key_empty}, 32'h1);
        send(8'h59); send(8'hE0); send(8'hF0); send(8'h59); send(8'h16);
        pop_check("rshift_bang", ek(8'h16, 8'h21));
        send(8'hF0); send(8'h59); send(8'h1E);
        pop_check("rshift_rel", ek(8'h1E, 8'h32));

        // Typematic repeat pushes each time.
        send(8'h29); send(8'h29); send(8'h5A);
        pop_check("rep0", ek(8'h29, 8'h20));
        pop_check("rep1", ek(8'h29, 8'h20));
        pop_check("enter", ek(8'h5A, 8'h0D));

        // Code with no ASCII mapping: dropped only in the ASCII build.
        send(8'h05);
        check("unmapped", {31'h0, key_empty}, {31'h0, ASCII});
        if (!key_empty) pop_check("unmapped_raw", 8'h05);

        // Pop on empty is ignored.
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check("pop_empty", {31'h0, key_empty}, 32'h1);
        send(8'h66);
        pop_check("bksp", ek(8'h66, 8'h08));

        // Nine keys with no reads: the ninth is dropped.
        for (int i = 0; i < 9; i++) send(sc_tab[i]);
        check("ovf_full", {31'h0, key_full}, 32'h1);
        check("ovf_flag", {31'h0, overflow}, 32'h1);
        for (int i = 0; i < 8; i++) pop_check($sformatf("ovf_rd%0d", i), ek(sc_tab[i], as_tab[i]));
        check("ovf_ninth_absent", {31'h0, key_empty}, 32'h1);
        check("ovf_sticky", {31'h0, overflow}, 32'h1);

        // Full FIFO with a pop coincident with a push tick.
        do_reset();
        check("rst2_ovf", {31'h0, overflow}, 32'h0);
        for (int i = 0; i < 8; i++) send(sc_tab[i]);
        check("fill_full", {31'h0, key_full}, 32'h1);
        check("fill_no_ovf", {31'h0, overflow}, 32'h0);
        @(negedge clk);
        rx_data      = 8'h42;
        rx_done_tick = 1'b1;
        rd_en        = 1'b1;
        @(negedge clk);
        rx_done_tick = 1'b0;
        rd_en        = 1'b0;
        check("pp_full", {31'h0, key_full}, 32'h1);
        check("pp_no_ovf", {31'h0, overflow}, 32'h0);
        for (int i = 1; i < 8; i++) pop_check($sformatf("pp_rd%0d", i), ek(sc_tab[i], as_tab[i]));
        pop_check("pp_last", ek(8'h42, 8'h6B));
        check("pp_drained", {31'h0, key_empty}, 32'h1);

        // Reset after a break prefix discards it.
        send(8'h1C);
        send(8'hF0);
        do_reset();
        check_reset_state("rst3");
        send(8'h1C);
        pop_check("post_rst", ek(8'h1C, 8'h61));
        check("post_rst_one", {31'h0, key_empty}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
